// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcodes, ALU control codes and ID/EX control record
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_SLT  = 4'b0100, ALU_BLTU = 4'b0101, ALU_SUB  = 4'b0110, ALU_BGEU = 4'b0111,
    ALU_SLL  = 4'b1000, ALU_XOR  = 4'b1001, ALU_SRL  = 4'b1010, ALU_SRA  = 4'b1011,
    ALU_BEQ  = 4'b1100, ALU_BNE  = 4'b1101, ALU_BLT  = 4'b1110, ALU_BGE  = 4'b1111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2
  } asel_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [4:0] rd;
    asel_t      asel;
    logic       bsel;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    valid: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
    branch: 1'b0, rd: 5'd0, asel: ASEL_RS1, bsel: 1'b0
  };

  // Shared by R-type and I-ALU; only R-type may turn funct7[5] into SUB.
  function automatic alu_ctrl_t arith_ctrl(input logic [2:0] funct3,
                                           input logic       funct7_5,
                                           input logic       is_rtype);
    alu_ctrl_t c;
    case (funct3)
      3'b000:  if (is_rtype && funct7_5) c = ALU_SUB; else c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  if (funct7_5) c = ALU_SRA; else c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// rtl/rv_alu_decoder.sv - opcode/funct decode into ALU control, operand selects and control bits
module rv_alu_decoder
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_ctrl,
  output logic [1:0] o_asel,
  output logic       o_bsel,
  output logic       o_regwrite,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_branch,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_illegal
);

  alu_ctrl_t w_ctrl;

  always_comb begin
    w_ctrl     = ALU_ADD;
    o_asel     = ASEL_RS1;
    o_bsel     = 1'b0;
    o_regwrite = 1'b0;
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_branch   = 1'b0;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_ctrl     = arith_ctrl(i_funct3, i_funct7_5, 1'b1);
        o_regwrite = 1'b1;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OP_I: begin
        w_ctrl     = arith_ctrl(i_funct3, i_funct7_5, 1'b0);
        o_regwrite = 1'b1;
        o_uses_rs1 = 1'b1;
        o_bsel     = 1'b1;
      end
      OP_LOAD: begin
        o_regwrite = 1'b1;
        o_memread  = 1'b1;
        o_uses_rs1 = 1'b1;
        o_bsel     = 1'b1;
      end
      OP_STORE: begin
        o_memwrite = 1'b1;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
        o_bsel     = 1'b1;
      end
      OP_BRANCH: begin
        o_branch   = 1'b1;
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
        case (i_funct3)
          3'b000:  w_ctrl = ALU_BEQ;
          3'b001:  w_ctrl = ALU_BNE;
          3'b100:  w_ctrl = ALU_BLT;
          3'b101:  w_ctrl = ALU_BGE;
          3'b110:  w_ctrl = ALU_BLTU;
          3'b111:  w_ctrl = ALU_BGEU;
          default: begin
            o_illegal  = 1'b1;
            o_branch   = 1'b0;
            o_uses_rs1 = 1'b0;
            o_uses_rs2 = 1'b0;
          end
        endcase
      end
      OP_LUI: begin
        o_regwrite = 1'b1;
        o_asel     = ASEL_ZERO;
        o_bsel     = 1'b1;
      end
      OP_AUIPC: begin
        o_regwrite = 1'b1;
        o_asel     = ASEL_PC;
        o_bsel     = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    o_alu_ctrl = w_ctrl;
  end

endmodule

// File: rtl/rv_id_ex_stage.sv
// rtl/rv_id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module rv_id_ex_stage
  import rv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [31:0]      i_id_instr,
  input  logic [WIDTH-1:0] i_id_pc,
  input  logic [WIDTH-1:0] i_id_rs1_data,
  input  logic [WIDTH-1:0] i_id_rs2_data,
  input  logic [WIDTH-1:0] i_id_imm,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [4:0]       i_exm_rd,
  input  logic             i_exm_regwrite,
  input  logic [WIDTH-1:0] i_exm_result,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_regwrite,
  input  logic [WIDTH-1:0] i_wb_result,
  output logic             o_ex_valid,
  output logic [WIDTH-1:0] o_ex_pc,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_ctrl,
  output logic [4:0]       o_ex_rd,
  output logic             o_ex_regwrite,
  output logic             o_ex_memread,
  output logic             o_ex_memwrite,
  output logic             o_ex_branch,
  output logic [WIDTH-1:0] o_ex_store_data,
  output logic             o_hazard_stall,
  output logic             o_illegal
);

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [3:0]  w_dec_alu_ctrl;
  logic [1:0]  w_dec_asel;
  logic        w_dec_bsel, w_dec_regwrite, w_dec_memread, w_dec_memwrite, w_dec_branch;
  logic        w_uses_rs1, w_uses_rs2, w_dec_illegal;
  logic        w_unused_instr;
  id_ex_ctrl_t w_load_ctrl;
  logic        w_hazard;
  logic [WIDTH-1:0] w_fwd_rs1, w_fwd_rs2;

  id_ex_ctrl_t      r_ctrl;
  alu_ctrl_t        r_alu_ctrl;
  logic [WIDTH-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]       r_rs1, r_rs2;
  logic             r_illegal;

  assign w_rs1          = i_id_instr[19:15];
  assign w_rs2          = i_id_instr[24:20];
  assign w_rd           = i_id_instr[11:7];
  assign w_unused_instr = ^{i_id_instr[31], i_id_instr[29:25]};

  rv_alu_decoder u_dec (
    .i_opcode   (i_id_instr[6:0]),
    .i_funct3   (i_id_instr[14:12]),
    .i_funct7_5 (i_id_instr[30]),
    .o_alu_ctrl (w_dec_alu_ctrl),
    .o_asel     (w_dec_asel),
    .o_bsel     (w_dec_bsel),
    .o_regwrite (w_dec_regwrite),
    .o_memread  (w_dec_memread),
    .o_memwrite (w_dec_memwrite),
    .o_branch   (w_dec_branch),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_dec_illegal)
  );

  // rd is zeroed for non-writers so stores/branches never look like forward or hazard sources.
  always_comb begin
    w_load_ctrl          = CTRL_BUBBLE;
    w_load_ctrl.valid    = 1'b1;
    w_load_ctrl.regwrite = w_dec_regwrite;
    w_load_ctrl.memread  = w_dec_memread;
    w_load_ctrl.memwrite = w_dec_memwrite;
    w_load_ctrl.branch   = w_dec_branch;
    w_load_ctrl.rd       = w_dec_regwrite ? w_rd : 5'd0;
    w_load_ctrl.asel     = asel_t'(w_dec_asel);
    w_load_ctrl.bsel     = w_dec_bsel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || w_hazard) begin
      r_ctrl     <= CTRL_BUBBLE;
      r_alu_ctrl <= ALU_ADD;
      r_pc       <= RESET_PC;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_illegal  <= 1'b0;
    end else if (i_stall) begin
      r_illegal  <= 1'b0;
    end else if (i_id_valid && !w_dec_illegal) begin
      r_ctrl     <= w_load_ctrl;
      r_alu_ctrl <= alu_ctrl_t'(w_dec_alu_ctrl);
      r_pc       <= i_id_pc;
      r_rs1_data <= i_id_rs1_data;
      r_rs2_data <= i_id_rs2_data;
      r_imm      <= i_id_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_illegal  <= 1'b0;
    end else begin
      r_ctrl     <= CTRL_BUBBLE;
      r_alu_ctrl <= ALU_ADD;
      r_pc       <= RESET_PC;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_illegal  <= i_id_valid;
    end
  end

  function automatic logic [WIDTH-1:0] fwd(input logic [4:0]       idx,
                                           input logic [WIDTH-1:0] data,
                                           input logic [4:0]       exm_rd,
                                           input logic             exm_we,
                                           input logic [WIDTH-1:0] exm_res,
                                           input logic [4:0]       wb_rd,
                                           input logic             wb_we,
                                           input logic [WIDTH-1:0] wb_res);
    if (idx == 5'd0)                        return '0;
    else if (exm_we && (exm_rd == idx))     return exm_res;
    else if (wb_we && (wb_rd == idx))       return wb_res;
    else                                    return data;
  endfunction

  always_comb begin
    w_fwd_rs1 = fwd(r_rs1, r_rs1_data, i_exm_rd, i_exm_regwrite, i_exm_result,
                    i_wb_rd, i_wb_regwrite, i_wb_result);
    w_fwd_rs2 = fwd(r_rs2, r_rs2_data, i_exm_rd, i_exm_regwrite, i_exm_result,
                    i_wb_rd, i_wb_regwrite, i_wb_result);
    case (r_ctrl.asel)
      ASEL_PC:   o_alu_a = r_pc;
      ASEL_ZERO: o_alu_a = '0;
      default:   o_alu_a = w_fwd_rs1;
    endcase
    o_alu_b         = r_ctrl.bsel ? r_imm : w_fwd_rs2;
    o_ex_store_data = w_fwd_rs2;
    w_hazard = r_ctrl.valid && r_ctrl.memread && (r_ctrl.rd != 5'd0) && i_id_valid && !i_flush &&
               ((w_uses_rs1 && (r_ctrl.rd == w_rs1)) || (w_uses_rs2 && (r_ctrl.rd == w_rs2)));
  end

  assign o_hazard_stall = w_hazard;
  assign o_ex_valid     = r_ctrl.valid;
  assign o_ex_pc        = r_pc;
  assign o_alu_ctrl     = r_alu_ctrl;
  assign o_ex_rd        = r_ctrl.rd;
  assign o_ex_regwrite  = r_ctrl.regwrite;
  assign o_ex_memread   = r_ctrl.memread;
  assign o_ex_memwrite  = r_ctrl.memwrite;
  assign o_ex_branch    = r_ctrl.branch;
  assign o_illegal      = r_illegal;

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// tb/tb_rv_id_ex_stage.sv - directed vector table plus multi-cycle sequences for rv_id_ex_stage
module tb_rv_id_ex_stage;

  localparam logic [31:0] RPC = 32'h0000_0080;
  localparam int OPR = 'h33, OPI = 'h13, OPL = 'h03, OPS = 'h23, OPB = 'h63;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_regwrite, wb_regwrite;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, hazard_stall, illegal;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_id_ex_stage #(.WIDTH(32), .RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_instr(id_instr), .i_id_pc(id_pc),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
    .i_stall(stall), .i_flush(flush),
    .i_exm_rd(exm_rd), .i_exm_regwrite(exm_regwrite), .i_exm_result(exm_result),
    .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite), .i_wb_result(wb_result),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_ctrl(alu_ctrl), .o_ex_rd(ex_rd), .o_ex_regwrite(ex_regwrite),
    .o_ex_memread(ex_memread), .o_ex_memwrite(ex_memwrite), .o_ex_branch(ex_branch),
    .o_ex_store_data(ex_store_data), .o_hazard_stall(hazard_stall), .o_illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr; logic vld; logic [31:0] rs1d, rs2d, imm, pc;
    logic [4:0] xrd; logic xrw; logic [31:0] xres;
    logic [4:0] wrd; logic wrw; logic [31:0] wres;
    logic e_valid; logic [3:0] e_ctrl; logic [31:0] e_a, e_b, e_st; logic [3:0] e_flags; logic [4:0] e_rd;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] enc(input int f7, input int rs2, input int rs1, input int f3,
                                      input int rd, input int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  task automatic add(input logic [31:0] instr, input int vld, input logic [31:0] rs1d, rs2d, imm, pc,
                     input int xrd, xrw, input logic [31:0] xres, input int wrd, wrw,
                     input logic [31:0] wres, input int ev, ectrl, input logic [31:0] ea, eb, est,
                     input int eflags, erd);
    vec_t v;
    v.instr = instr; v.vld = vld[0]; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm; v.pc = pc;
    v.xrd = xrd[4:0]; v.xrw = xrw[0]; v.xres = xres; v.wrd = wrd[4:0]; v.wrw = wrw[0]; v.wres = wres;
    v.e_valid = ev[0]; v.e_ctrl = ectrl[3:0]; v.e_a = ea; v.e_b = eb; v.e_st = est;
    v.e_flags = eflags[3:0]; v.e_rd = erd[4:0];
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] ins, rs1d, rs2d, imm, pc);
    id_valid = v; id_instr = ins; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm; id_pc = pc;
  endtask

  task automatic set_fwd(input logic [4:0] xrd, input logic xrw, input logic [31:0] xres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    exm_rd = xrd; exm_regwrite = xrw; exm_result = xres;
    wb_rd = wrd; wb_regwrite = wrw; wb_result = wres;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_fwd(5'd3, 1'b1, 32'hAAAA, 5'd3, 1'b1, 32'hBBBB);

    // instr, vld, rs1d, rs2d, imm, pc, xrd, xrw, xres, wrd, wrw, wres | valid, ctrl, a, b, store, {rw,mr,mw,br}, rd
    add(enc(0,2,1,0,3,OPR),     1, 100, 50, 0, 'h1000, 0,0,0, 0,0,0,      1, 'b0010, 100, 50, 50, 'b1000, 3);
    add(enc('h20,2,1,0,5,OPR),  1, 11, 20, 0, 'h1004,  1,1,7, 1,1,9,      1, 'b0110, 7, 20, 20, 'b1000, 5);
    add(enc('h20,2,1,0,5,OPR),  1, 11, 20, 0, 'h1008,  0,1,7, 1,0,9,      1, 'b0110, 11, 20, 20, 'b1000, 5);
    add(enc(0,2,1,0,3,OPR),     1, 1, 2, 0, 'h100C,    0,0,0, 2,1,33,     1, 'b0010, 1, 33, 33, 'b1000, 3);
    add(enc(0,2,1,4,10,OPR),    1, 'hF0, 'hFF, 0, 'h1010, 1,0,7, 1,1,9,  1, 'b1001, 9, 'hFF, 'hFF, 'b1000, 10);
    add(enc(0,2,0,6,11,OPR),    1, 'h55, 'h0F, 0, 'h1014, 0,1,'h77, 0,1,'h66, 1, 'b0001, 0, 'h0F, 'h0F, 'b1000, 11);
    add(enc('h20,2,1,5,12,OPR), 1, 'h80, 3, 0, 'h1018,  0,0,0, 0,0,0,     1, 'b1011, 'h80, 3, 3, 'b1000, 12);
    add(enc(0,2,1,5,12,OPR),    1, 'h80, 3, 0, 'h101C,  0,0,0, 0,0,0,     1, 'b1010, 'h80, 3, 3, 'b1000, 12);
    add(enc(0,2,1,2,13,OPR),    1, 4, 5, 0, 'h1020,     0,0,0, 0,0,0,     1, 'b0100, 4, 5, 5, 'b1000, 13);
    add(enc(0,2,1,3,13,OPR),    1, 4, 5, 0, 'h1024,     0,0,0, 0,0,0,     1, 'b0011, 4, 5, 5, 'b1000, 13);
    add(enc(0,2,1,7,13,OPR),    1, 4, 5, 0, 'h1028,     0,0,0, 0,0,0,     1, 'b0000, 4, 5, 5, 'b1000, 13);
    add(enc(0,2,1,1,13,OPR),    1, 4, 5, 0, 'h102C,     0,0,0, 0,0,0,     1, 'b1000, 4, 5, 5, 'b1000, 13);
    add(enc('h7F,'h1F,1,0,1,OPI), 1, 10, 'h77, 'hFFFFFFFF, 'h1030, 0,0,0, 0,0,0, 1, 'b0010, 10, 'hFFFFFFFF, 'h77, 'b1000, 1);
    add(enc('h20,4,1,5,7,OPI),  1, 'h80000000, 0, 4, 'h1034, 0,0,0, 0,0,0, 1, 'b1011, 'h80000000, 4, 0, 'b1000, 7);
    add(enc(0,4,1,5,7,OPI),     1, 'h80000000, 0, 4, 'h1038, 0,0,0, 0,0,0, 1, 'b1010, 'h80000000, 4, 0, 'b1000, 7);
    add(enc(0,4,1,3,7,OPI),     1, 9, 0, 4, 'h103C,     0,0,0, 0,0,0,     1, 'b0011, 9, 4, 0, 'b1000, 7);
    add(enc(0,4,1,7,7,OPI),     1, 9, 0, 4, 'h1040,     0,0,0, 0,0,0,     1, 'b0000, 9, 4, 0, 'b1000, 7);
    add(enc(0,4,1,6,7,OPI),     1, 9, 0, 4, 'h1044,     0,0,0, 0,0,0,     1, 'b0001, 9, 4, 0, 'b1000, 7);
    add(32'h12345437,           1, 99, 0, 'h12345000, 'h1048, 0,0,0, 0,0,0, 1, 'b0010, 0, 'h12345000, 0, 'b1000, 8);
    add(32'h00001497,           1, 5, 0, 'h1000, 'h400, 0,0,0, 0,0,0,     1, 'b0010, 'h400, 'h1000, 0, 'b1000, 9);
    add(enc(0,2,1,2,8,OPS),     1, 'h100, 'hDEAD, 8, 'h104C, 0,0,0, 0,0,0, 1, 'b0010, 'h100, 8, 'hDEAD, 'b0010, 0);
    add(enc(0,0,1,2,4,OPL),     1, 'h200, 0, 0, 'h1050, 0,0,0, 0,0,0,     1, 'b0010, 'h200, 0, 0, 'b1100, 4);
    add(enc(0,2,1,0,3,OPR),     0, 5, 6, 0, 'h1054,     0,0,0, 0,0,0,     0, 'b0010, 0, 0, 0, 'b0000, 0);
    add(enc(0,2,1,6,0,OPB),     1, 5, 6, 0, 'h1058,     0,0,0, 0,0,0,     1, 'b0101, 5, 6, 6, 'b0001, 0);
    add(enc(0,2,1,0,'h1A,OPB),  1, 5, 6, 0, 'h105C,     0,0,0, 0,0,0,     1, 'b1100, 5, 6, 6, 'b0001, 0);
    add(enc(0,2,1,1,0,OPB),     1, 5, 6, 0, 'h1060,     0,0,0, 0,0,0,     1, 'b1101, 5, 6, 6, 'b0001, 0);
    add(enc(0,2,1,4,0,OPB),     1, 5, 6, 0, 'h1064,     0,0,0, 0,0,0,     1, 'b1110, 5, 6, 6, 'b0001, 0);
    add(enc(0,2,1,5,0,OPB),     1, 5, 6, 0, 'h1068,     0,0,0, 0,0,0,     1, 'b1111, 5, 6, 6, 'b0001, 0);
    add(enc(0,2,1,7,0,OPB),     1, 5, 6, 0, 'h106C,     0,0,0, 0,0,0,     1, 'b0111, 5, 6, 6, 'b0001, 0);

    tick; tick;
    chk("rst valid", 32'(ex_valid), 0);
    chk("rst pc", ex_pc, RPC);
    chk("rst ctrl", 32'(alu_ctrl), 'b0010);
    chk("rst a", alu_a, 0);
    chk("rst b", alu_b, 0);
    chk("rst store", ex_store_data, 0);
    chk("rst flags", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch}), 0);
    chk("rst rd", 32'(ex_rd), 0);
    chk("rst illegal", 32'(illegal), 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      set_id(vt[i].vld, vt[i].instr, vt[i].rs1d, vt[i].rs2d, vt[i].imm, vt[i].pc);
      set_fwd(vt[i].xrd, vt[i].xrw, vt[i].xres, vt[i].wrd, vt[i].wrw, vt[i].wres);
      tick;
      chk($sformatf("v%0d valid", i), 32'(ex_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d pc", i), ex_pc, vt[i].e_valid ? vt[i].pc : RPC);
      chk($sformatf("v%0d ctrl", i), 32'(alu_ctrl), 32'(vt[i].e_ctrl));
      chk($sformatf("v%0d a", i), alu_a, vt[i].e_a);
      chk($sformatf("v%0d b", i), alu_b, vt[i].e_b);
      chk($sformatf("v%0d store", i), ex_store_data, vt[i].e_st);
      chk($sformatf("v%0d flags", i), 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch}), 32'(vt[i].e_flags));
      chk($sformatf("v%0d rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
      chk($sformatf("v%0d illegal", i), 32'(illegal), 0);
      chk($sformatf("v%0d hazard", i), 32'(hazard_stall), 0);
    end

    // load-use: LW x4 then a dependent ADD
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, enc(0,0,1,2,4,OPL), 32'h200, 32'h0, 32'h0, 32'h2000);
    tick;
    chk("lu memread", 32'(ex_memread), 1);
    set_id(1'b1, enc(0,4,1,0,6,OPI), 32'h11, 32'h0, 32'h4, 32'h2004);
    #1 chk("lu imm-field no hazard", 32'(hazard_stall), 0);
    set_id(1'b1, enc(0,2,4,0,6,OPR), 32'h11, 32'h22, 32'h0, 32'h2004);
    #1 chk("lu hazard", 32'(hazard_stall), 1);
    flush = 1'b1;
    #1 chk("lu hazard under flush", 32'(hazard_stall), 0);
    flush = 1'b0;
    tick;
    chk("lu bubble valid", 32'(ex_valid), 0);
    chk("lu bubble regwrite", 32'(ex_regwrite), 0);
    chk("lu hazard cleared", 32'(hazard_stall), 0);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h1234);
    tick;
    chk("lu add valid", 32'(ex_valid), 1);
    chk("lu add a", alu_a, 32'h1234);
    chk("lu add b", alu_b, 32'h22);
    chk("lu add rd", 32'(ex_rd), 6);

    // stall hold for three cycles, then flush during stall
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, enc(0,2,1,0,3,OPR), 32'd100, 32'd50, 32'h0, 32'h3000);
    tick;
    set_id(1'b1, enc(0,2,1,4,9,OPR), 32'd7, 32'd8, 32'h0, 32'h3004);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("stall%0d valid", k), 32'(ex_valid), 1);
      chk($sformatf("stall%0d pc", k), ex_pc, 32'h3000);
      chk($sformatf("stall%0d ctrl", k), 32'(alu_ctrl), 'b0010);
      chk($sformatf("stall%0d a", k), alu_a, 100);
      chk($sformatf("stall%0d rd", k), 32'(ex_rd), 3);
    end
    flush = 1'b1;
    tick;
    chk("flush valid", 32'(ex_valid), 0);
    chk("flush regwrite", 32'(ex_regwrite), 0);
    chk("flush pc", ex_pc, RPC);
    flush = 1'b0; stall = 1'b0;

    // reset mid-stream with live forwarding inputs
    set_id(1'b1, enc(0,2,1,2,8,OPS), 32'h100, 32'hDEAD, 32'h8, 32'h4000);
    tick;
    chk("pre-rst memwrite", 32'(ex_memwrite), 1);
    set_fwd(5'd1, 1'b1, 32'h5555, 5'd2, 1'b1, 32'h6666);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid-rst valid", 32'(ex_valid), 0);
    chk("mid-rst memwrite", 32'(ex_memwrite), 0);
    chk("mid-rst ctrl", 32'(alu_ctrl), 'b0010);
    chk("mid-rst a", alu_a, 0);
    chk("mid-rst store", ex_store_data, 0);
    chk("mid-rst pc", ex_pc, RPC);

    // unsupported opcode -> one-cycle illegal pulse and a bubble
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, enc(0,2,1,0,3,'h7F), 32'h1, 32'h2, 32'h0, 32'h5000);
    tick;
    chk("illegal pulse", 32'(illegal), 1);
    chk("illegal bubble", 32'(ex_valid), 0);
    chk("illegal regwrite", 32'(ex_regwrite), 0);
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick;
    chk("illegal cleared", 32'(illegal), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
